// File: rtl/pc_gen_if.sv
// Fetch-request channel between the PC generator (master) and the instruction cache (slave).
interface pc_gen_if #(
    parameter int ADDR_W = 32
);
    logic              if_req_valid;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_req_ready;

    modport master (
        output if_req_valid,
        output if_req_addr,
        input  if_req_ready
    );

    modport slave (
        input  if_req_valid,
        input  if_req_addr,
        output if_req_ready
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch PC generator: BOOT/RUN/HALT sequencing, sequential fetch, prioritised
// execute/decode redirects with an epoch tag and a misaligned-target pulse.
module pc_gen #(
    parameter int          ADDR_W    = 32,
    parameter logic [63:0] RESET_VEC = '0,
    parameter int unsigned STEP      = 4,
    parameter int          EPOCH_W   = 2
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               stall_in,
    input  logic               halt_in,
    input  logic               redir_ex_valid,
    input  logic [ADDR_W-1:0]  redir_ex_addr,
    input  logic               redir_id_valid,
    input  logic [ADDR_W-1:0]  redir_id_addr,
    pc_gen_if.master           if_req,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [EPOCH_W-1:0] epoch_out,
    output logic               ce,
    output logic               misalign_out
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] RESET_PC = {RESET_VEC[ADDR_W-1:2], 2'b00};
    localparam logic [ADDR_W-1:0] STEP_INC = ADDR_W'(STEP);

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [EPOCH_W-1:0]   epoch_q, epoch_d;
    logic                 mis_q, mis_d;

    logic                 req_valid;
    logic                 fire;
    logic                 redir_any;
    logic                 redir_acc;
    logic [ADDR_W-1:0]    redir_tgt;

    always_comb begin
        req_valid = rdy_in && (state_q == ST_RUN) && !stall_in;
        fire      = req_valid && if_req.if_req_ready;
        redir_any = redir_ex_valid || redir_id_valid;
        // Execute-stage redirect is older in program order, so it wins.
        redir_tgt = redir_ex_valid ? redir_ex_addr : redir_id_addr;
        redir_acc = rdy_in && (state_q != ST_BOOT) && redir_any;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epoch_d = epoch_q;
        mis_d   = mis_q;

        if (rdy_in) begin
            mis_d = 1'b0;
            unique case (state_q)
                ST_BOOT: state_d = ST_RUN;
                ST_RUN:  if (halt_in && !redir_any) state_d = ST_HALT;
                ST_HALT: if (redir_any) state_d = ST_RUN;
                default: state_d = ST_BOOT;
            endcase

            // A redirect overrides any sequential advance in the same cycle.
            if (redir_acc) begin
                pc_d    = {redir_tgt[ADDR_W-1:2], 2'b00};
                epoch_d = epoch_q + EPOCH_W'(1);
                mis_d   = |redir_tgt[1:0];
            end else if (fire) begin
                pc_d = pc_q + STEP_INC;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            epoch_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epoch_q <= epoch_d;
            mis_q   <= mis_d;
        end
    end

    assign if_req.if_req_valid = req_valid;
    assign if_req.if_req_addr  = pc_q;
    assign pc_out              = pc_q;
    assign epoch_out           = epoch_q;
    assign ce                  = (state_q == ST_RUN);
    assign misalign_out        = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed and randomised bench for pc_gen against a behavioural fetch model,
// plus a narrow-address instance for PC wrap and epoch wrap.
module tb_pc_gen;
    localparam int AW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main 32-bit instance
    logic          rst_n, rdy, stall, halt, ex_v, id_v;
    logic [AW-1:0] ex_a, id_a, pc;
    logic [1:0]    epoch;
    logic          ce, mis;

    pc_gen_if #(.ADDR_W(AW)) bus ();

    pc_gen #(.ADDR_W(AW)) dut (
        .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .stall_in(stall), .halt_in(halt),
        .redir_ex_valid(ex_v), .redir_ex_addr(ex_a),
        .redir_id_valid(id_v), .redir_id_addr(id_a),
        .if_req(bus), .pc_out(pc), .epoch_out(epoch), .ce(ce), .misalign_out(mis)
    );

    // Narrow 8-bit instance
    logic       rst8_n, rdy8, stall8, halt8, ex8_v, id8_v;
    logic [7:0] ex8_a, id8_a, pc8;
    logic [1:0] epoch8;
    logic       ce8, mis8;

    pc_gen_if #(.ADDR_W(8)) bus8 ();

    pc_gen #(.ADDR_W(8)) dut8 (
        .clk_in(clk), .rst_in(rst8_n), .rdy_in(rdy8), .stall_in(stall8), .halt_in(halt8),
        .redir_ex_valid(ex8_v), .redir_ex_addr(ex8_a),
        .redir_id_valid(id8_v), .redir_id_addr(id8_a),
        .if_req(bus8), .pc_out(pc8), .epoch_out(epoch8), .ce(ce8), .misalign_out(mis8)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: started / halted flags, PC, epoch, misalign pulse
    bit          m_booted, m_halted, m_mis;
    logic [31:0] m_pc;
    int          m_epoch;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_valid();
        return m_booted && !m_halted && !stall && rdy;
    endfunction

    task automatic model_reset();
        m_booted = 1'b0;
        m_halted = 1'b0;
        m_mis    = 1'b0;
        m_pc     = 32'h0;
        m_epoch  = 0;
    endtask

    task automatic model_step();
        bit          fire;
        logic [31:0] tgt;
        fire = exp_valid() && bus.if_req_ready;
        if (!rdy) return;
        if (!m_booted) begin
            m_booted = 1'b1;
            m_mis    = 1'b0;
        end else if (ex_v || id_v) begin
            tgt      = ex_v ? ex_a : id_a;
            m_pc     = tgt & ~32'h3;
            m_epoch  = (m_epoch + 1) % 4;
            m_mis    = (tgt % 4) != 0;
            m_halted = 1'b0;
        end else begin
            m_mis = 1'b0;
            if (fire) m_pc = m_pc + 32'd4;
            if (halt) m_halted = 1'b1;
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".valid"}, bus.if_req_valid, exp_valid());
        chk({ctx, ".addr"},  bus.if_req_addr,  m_pc);
        chk({ctx, ".pc"},    pc,               m_pc);
        chk({ctx, ".epoch"}, epoch,            m_epoch);
        chk({ctx, ".ce"},    ce,               m_booted && !m_halted);
        chk({ctx, ".mis"},   mis,              m_mis);
    endtask

    // Inputs are set 1 time unit after a rising edge; outputs are checked mid-cycle.
    task automatic cyc(input string ctx);
        #3;
        check_all(ctx);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick8();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; stall = 1'b0; halt = 1'b0;
        ex_v = 1'b0; id_v = 1'b0; ex_a = '0; id_a = '0;
        bus.if_req_ready = 1'b1;
        rst8_n = 1'b0; rdy8 = 1'b1; stall8 = 1'b0; halt8 = 1'b0;
        ex8_v = 1'b0; id8_v = 1'b0; ex8_a = '0; id8_a = '0;
        bus8.if_req_ready = 1'b1;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_all("reset");

        // Boot and sequential fetch 0x0, 0x4, 0x8, 0xC
        rst_n = 1'b1;
        cyc("boot");
        repeat (4) cyc("seq");
        chk("seq_end_pc", pc, 32'h10);

        // Cache not ready for three cycles at 0x10
        bus.if_req_ready = 1'b0;
        repeat (3) cyc("hold");
        bus.if_req_ready = 1'b1;
        cyc("resume");
        chk("resume_pc", pc, 32'h14);

        // Simultaneous execute and decode redirects with a fire
        ex_v = 1'b1; ex_a = 32'h200; id_v = 1'b1; id_a = 32'h300;
        cyc("dual");
        ex_v = 1'b0; id_v = 1'b0;
        chk("dual_addr", bus.if_req_addr, 32'h200);
        chk("dual_epoch", epoch, 2'd1);

        // Halt, idle, then wake with a misaligned decode redirect
        halt = 1'b1;
        cyc("halt");
        halt = 1'b0;
        repeat (5) cyc("halted");
        id_v = 1'b1; id_a = 32'h103;
        cyc("wake");
        id_v = 1'b0;
        chk("wake_addr", bus.if_req_addr, 32'h100);
        chk("wake_mis", mis, 1'b1);
        cyc("after_wake");

        // Global ready low: redirect and stall toggling must be ignored
        rdy = 1'b0; ex_v = 1'b1; ex_a = 32'h40;
        for (int i = 0; i < 4; i++) begin
            stall = i[0];
            cyc("rdy_low");
        end
        rdy = 1'b1; ex_v = 1'b0; stall = 1'b0;
        cyc("rdy_back");

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            rdy              = ($urandom_range(0, 9) != 0);
            stall            = ($urandom_range(0, 3) == 0);
            bus.if_req_ready = $urandom_range(0, 1) == 1;
            halt             = ($urandom_range(0, 15) == 0);
            ex_v             = ($urandom_range(0, 11) == 0);
            id_v             = ($urandom_range(0, 9) == 0);
            ex_a             = $urandom;
            id_a             = $urandom;
            cyc("rand");
        end

        // Asynchronous reset in the middle of a fetch
        rdy = 1'b1; stall = 1'b0; halt = 1'b0; ex_v = 1'b0; id_v = 1'b0;
        bus.if_req_ready = 1'b1;
        id_v = 1'b1; id_a = 32'h500;
        cyc("pre_rst");
        id_v = 1'b0;
        cyc("pre_rst2");
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_held");
        rst_n = 1'b1;
        repeat (3) cyc("reboot");

        // 8-bit instance: PC wrap and epoch wrap
        rst8_n = 1'b1;
        tick8();                              // BOOT -> RUN
        id8_v = 1'b1; id8_a = 8'hFC;
        tick8();
        id8_v = 1'b0;
        chk("w8_load", pc8, 8'hFC);
        chk("w8_epoch1", epoch8, 2'd1);
        tick8();
        chk("w8_wrap", pc8, 8'h00);
        ex8_v = 1'b1; ex8_a = 8'h10;
        tick8();
        tick8();
        chk("w8_epoch3", epoch8, 2'd3);
        ex8_a = 8'h24;
        tick8();
        ex8_v = 1'b0;
        chk("w8_epoch_wrap", epoch8, 2'd0);
        chk("w8_redir_pc", pc8, 8'h24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
